// File: rtl/debounce_pkg.sv
// Shared types and helpers for the time-multiplexed debounce scheduler.
package debounce_pkg;

  typedef enum logic [1:0] {IDLE, INIT, RUN} t_sched_state;

  // Width of a per-channel agreement counter able to hold 0..scale.
  function automatic int unsigned cnt_width(input int unsigned scale);
    return $clog2(scale + 1);
  endfunction

endpackage

// File: rtl/debounce_scheduler_if.sv
// Pad-side inputs and debounced outputs of the debounce scheduler.
interface debounce_scheduler_if #(
  parameter int unsigned p_channels = 4
);

  logic [p_channels-1:0] i_in;
  logic                  i_en;
  logic [p_channels-1:0] o_out;
  logic [p_channels-1:0] o_rise;
  logic [p_channels-1:0] o_fall;
  logic                  o_ready;

  modport master (
    output i_in,
    output i_en,
    input  o_out,
    input  o_rise,
    input  o_fall,
    input  o_ready
  );

  modport slave (
    input  i_in,
    input  i_en,
    output o_out,
    output o_rise,
    output o_fall,
    output o_ready
  );

endinterface

// File: rtl/debounce_scheduler_tick_gen.sv
// Prescaler: one-cycle tick every p_prescale enabled clocks; frozen while i_en is low.
module tick_gen #(
  parameter int unsigned p_prescale = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_tick
);

  localparam int unsigned PreW = (p_prescale > 1) ? $clog2(p_prescale) : 1;
  localparam logic [PreW-1:0] Last = PreW'(p_prescale - 1);

  logic [PreW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (i_en) begin
      count_d = (count_q == Last) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_tick = i_en && (count_q == Last);

endmodule

// File: rtl/debounce_scheduler.sv
// Round-robin debounce: one shared hysteresis engine services one channel per prescaler tick.
module debounce_scheduler
  import debounce_pkg::*;
#(
  parameter int unsigned p_channels = 4,
  parameter int unsigned p_scale    = 5,
  parameter int unsigned p_prescale = 16
) (
  input logic                 i_clk,
  input logic                 i_rst,
  debounce_scheduler_if.slave bus
);

  localparam int unsigned CntW = cnt_width(p_scale);
  localparam int unsigned ChW  = (p_channels > 1) ? $clog2(p_channels) : 1;
  localparam logic [ChW-1:0]  LastCh    = ChW'(p_channels - 1);
  localparam logic [CntW-1:0] ScaleLast = CntW'(p_scale - 1);

  t_sched_state state_q, state_d;

  logic                  tick;
  logic [p_channels-1:0] sync1_q, s_q;
  logic [ChW-1:0]        ch_q, ch_d;
  logic [p_channels-1:0] stable_q, stable_d;
  logic [CntW-1:0]       cnt_q [p_channels];
  logic [CntW-1:0]       cnt_d [p_channels];
  logic [p_channels-1:0] rise_q, rise_d, fall_q, fall_d;
  logic                  ready_q;
  logic                  init_svc, run_svc, ready_set;
  logic                  cur_s;

  tick_gen #(
    .p_prescale (p_prescale)
  ) u_tick_gen (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (bus.i_en),
    .o_tick (tick)
  );

  // Two-flop synchronizer; everything downstream sees only s_q.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1_q <= '0;
      s_q     <= '0;
    end else begin
      sync1_q <= bus.i_in;
      s_q     <= sync1_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = INIT;
      INIT:    if (tick && (ch_q == LastCh)) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    init_svc  = (state_q == INIT) && tick;
    run_svc   = (state_q == RUN) && tick;
    ready_set = init_svc && (ch_q == LastCh);
  end

  assign cur_s = s_q[ch_q];

  always_comb begin
    ch_d = ch_q;
    if (init_svc || run_svc) begin
      ch_d = (ch_q == LastCh) ? '0 : ch_q + 1'b1;
    end
  end

  // Shared engine: only the pointed-to channel's level/counter can change this cycle.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    rise_d   = '0;
    fall_d   = '0;
    if (init_svc) begin
      stable_d[ch_q] = cur_s;
      cnt_d[ch_q]    = '0;
    end else if (run_svc) begin
      if (cur_s == stable_q[ch_q]) begin
        cnt_d[ch_q] = '0;
      end else if (cnt_q[ch_q] == ScaleLast) begin
        stable_d[ch_q] = cur_s;
        cnt_d[ch_q]    = '0;
        rise_d[ch_q]   = cur_s;
        fall_d[ch_q]   = ~cur_s;
      end else begin
        cnt_d[ch_q] = cnt_q[ch_q] + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ch_q     <= '0;
      stable_q <= '0;
      cnt_q    <= '{default: '0};
      rise_q   <= '0;
      fall_q   <= '0;
      ready_q  <= 1'b0;
    end else begin
      ch_q     <= ch_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      if (ready_set) ready_q <= 1'b1;
    end
  end

  assign bus.o_out   = stable_q;
  assign bus.o_rise  = rise_q;
  assign bus.o_fall  = fall_q;
  assign bus.o_ready = ready_q;

endmodule

// File: tb/tb_debounce_scheduler.sv
// Scoreboard bench for debounce_scheduler (4 channels, scale 3, prescale 4).
module tb_debounce_scheduler;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  rise;
    logic [3:0]  fall;
    logic [3:0]  out;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;
  exp_t        exp_q[$];
  exp_t        e;

  debounce_scheduler_if #(.p_channels(4)) bus ();

  debounce_scheduler #(
    .p_channels (4),
    .p_scale    (3),
    .p_prescale (4)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Edge number since the last reset release.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, want, cyc);
    end
  endtask

  task automatic push(input int unsigned c, input logic [3:0] r, input logic [3:0] f,
                      input logic [3:0] o);
    exp_t x;
    x.cyc  = c;
    x.rise = r;
    x.fall = f;
    x.out  = o;
    exp_q.push_back(x);
  endtask

  task automatic wait_cyc(input int unsigned n);
    while (cyc < n) @(negedge clk);
  endtask

  // Monitor: every edge pulse must match the next expected event exactly.
  always @(negedge clk) begin
    if (!rst && ((bus.o_rise | bus.o_fall) != 4'b0000)) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got rise=%b fall=%b want none (cyc %0d)",
                 bus.o_rise, bus.o_fall, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("evt_cyc", cyc, e.cyc);
        chk("evt_rise", {28'd0, bus.o_rise}, {28'd0, e.rise});
        chk("evt_fall", {28'd0, bus.o_fall}, {28'd0, e.fall});
        chk("evt_out", {28'd0, bus.o_out}, {28'd0, e.out});
        chk("evt_onehot", {31'd0, $onehot0(bus.o_rise | bus.o_fall)}, 32'd1);
      end
    end
  end

  initial begin
    rst       = 1'b1;
    bus.i_en  = 1'b1;
    bus.i_in  = 4'b0101;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out", {28'd0, bus.o_out}, 32'h0);
    chk("reset_ready", {31'd0, bus.o_ready}, 32'h0);
    chk("reset_pulses", {28'd0, bus.o_rise | bus.o_fall}, 32'h0);
    rst = 1'b0;

    // INIT sweep: ch0..ch3 sampled at edges 4, 8, 12, 16.
    wait_cyc(15);
    chk("ready_before_sweep", {31'd0, bus.o_ready}, 32'h0);
    wait_cyc(16);
    chk("ready_after_sweep", {31'd0, bus.o_ready}, 32'h1);
    chk("init_out", {28'd0, bus.o_out}, 32'h5);

    // Release ch0/ch2: third services at 52 (ch0) and 60 (ch2).
    bus.i_in = 4'b0000;
    push(52, 4'b0000, 4'b0001, 4'b0100);
    push(60, 4'b0000, 4'b0100, 4'b0000);
    wait_cyc(64);
    chk("all_low", {28'd0, bus.o_out}, 32'h0);

    // ch1 rise: services 72, 88, 104.
    bus.i_in = 4'b0010;
    push(104, 4'b0010, 4'b0000, 4'b0010);
    wait_cyc(103);
    chk("ch1_before_third", {28'd0, bus.o_out}, 32'h0);

    // ch2 glitch seen by services 108 and 124 only, cleared at 140.
    wait_cyc(104);
    bus.i_in = 4'b0110;
    wait_cyc(124);
    bus.i_in = 4'b0010;
    wait_cyc(140);
    chk("glitch_rejected", {28'd0, bus.o_out}, 32'h2);
    // Full change needs three fresh services: 156, 172, 188.
    bus.i_in = 4'b0110;
    push(188, 4'b0100, 4'b0000, 4'b0110);

    // Freeze for 100 edges; resume at ch3 on 292, ch0 flips at 328.
    wait_cyc(190);
    bus.i_en = 1'b0;
    bus.i_in = 4'b0111;
    push(328, 4'b0001, 4'b0000, 4'b0111);
    wait_cyc(240);
    chk("frozen_out_mid", {28'd0, bus.o_out}, 32'h6);
    wait_cyc(290);
    chk("frozen_out_end", {28'd0, bus.o_out}, 32'h6);
    chk("frozen_ready", {31'd0, bus.o_ready}, 32'h1);
    bus.i_en = 1'b1;

    // Drop all: ch1 at 364, ch2 at 368, ch0 at 376.
    wait_cyc(328);
    bus.i_in = 4'b0000;
    push(364, 4'b0000, 4'b0010, 4'b0101);
    push(368, 4'b0000, 4'b0100, 4'b0001);
    push(376, 4'b0000, 4'b0001, 4'b0000);

    // Simultaneous rise aligned so ch0 is serviced first (392).
    wait_cyc(388);
    bus.i_in = 4'b1111;
    push(424, 4'b0001, 4'b0000, 4'b0001);
    push(428, 4'b0010, 4'b0000, 4'b0011);
    push(432, 4'b0100, 4'b0000, 4'b0111);
    push(436, 4'b1000, 4'b0000, 4'b1111);

    wait_cyc(440);
    chk("all_high", {28'd0, bus.o_out}, 32'hf);
    chk("events_drained", exp_q.size(), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_out", {28'd0, bus.o_out}, 32'h0);
    chk("async_reset_ready", {31'd0, bus.o_ready}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    wait_cyc(15);
    chk("resweep_ready_low", {31'd0, bus.o_ready}, 32'h0);
    wait_cyc(16);
    chk("resweep_ready_high", {31'd0, bus.o_ready}, 32'h1);
    chk("resweep_out", {28'd0, bus.o_out}, 32'hf);
    wait_cyc(60);
    chk("final_out", {28'd0, bus.o_out}, 32'hf);
    chk("no_pending", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
